// File: rtl/montgomery_radix.sv
// Iterative Montgomery multiplier: result = a*b*2^-WIDTH mod m, ITER_PER_CYCLE bit-iterations per clock.
// Define MONT_FINAL_SUB_EN to add the SUB state that reduces the result fully into [0, m).
module montgomery_radix #(
  parameter int WIDTH          = 1024,
  parameter int ITER_PER_CYCLE = 2,
  parameter int CNT_W          = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);
  localparam int               NCYC     = WIDTH / ITER_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOOP = 2'd1, S_SUB = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic [WIDTH+1:0] c_q, c_d, c_step;
  logic             done_q, done_d;
  logic             last_iter;

  // One radix-2 Montgomery iteration; C < 2m keeps t + m below 2^(WIDTH+2).
  function automatic logic [WIDTH+1:0] mont_step(input logic [WIDTH+1:0] c,
                                                 input logic             a_bit,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] t;
    t = c + (a_bit ? {2'b00, b} : '0);
    if (t[0]) t = t + {2'b00, m};
    return t >> 1;
  endfunction

`ifdef MONT_FINAL_SUB_EN
  function automatic logic [WIDTH-1:0] final_reduce(input logic [WIDTH+1:0] c,
                                                    input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] d;
    d = c - {2'b00, m};
    return d[WIDTH+1] ? c[WIDTH-1:0] : d[WIDTH-1:0];
  endfunction
`endif

  assign last_iter = (cnt_q == LAST_CNT);

  always_comb begin
    c_step = c_q;
    for (int j = 0; j < ITER_PER_CYCLE; j++) begin
      c_step = mont_step(c_step, a_q[j], b_q, m_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOOP;
      S_LOOP: begin
        if (last_iter) begin
`ifdef MONT_FINAL_SUB_EN
          state_d = S_SUB;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_SUB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = in_a;
          b_d   = in_b;
          m_d   = in_m;
          c_d   = '0;
          cnt_d = '0;
        end
      end
      S_LOOP: begin
        c_d   = c_step;
        a_d   = a_q >> ITER_PER_CYCLE;
        cnt_d = cnt_q + CNT_W'(1);
`ifndef MONT_FINAL_SUB_EN
        if (last_iter) begin
          result_d = c_step[WIDTH-1:0];
          done_d   = 1'b1;
        end
`endif
      end
`ifdef MONT_FINAL_SUB_EN
      S_SUB: begin
        result_d = final_reduce(c_q, m_q);
        done_d   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
endmodule

// File: tb/tb_montgomery_radix.sv
// Directed bench for montgomery_radix: 8-bit instances at K=1,2,4,8 plus one 1024-bit instance.
module tb_montgomery_radix;
  localparam int W  = 8;
  localparam int WL = 1024;
`ifdef MONT_FINAL_SUB_EN
  localparam int XTRA = 2;
`else
  localparam int XTRA = 1;
`endif
  localparam int LAT = W / 2 + XTRA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [3:0]          st;
  logic [W-1:0]        a8, b8, m8;
  logic [3:0][W-1:0]   res8;
  logic [3:0]          done8, busy8;

  logic                stL;
  logic [WL-1:0]       aL, bL, mL, resL;
  logic                doneL, busyL;

  for (genvar g = 0; g < 4; g++) begin : g_k
    montgomery_radix #(.WIDTH(W), .ITER_PER_CYCLE(1 << g), .CNT_W(4)) u_dut (
      .clk(clk), .reset(reset), .start(st[g]), .in_a(a8), .in_b(b8), .in_m(m8),
      .result(res8[g]), .done(done8[g]), .busy(busy8[g]));
  end

  montgomery_radix #(.WIDTH(WL), .ITER_PER_CYCLE(2), .CNT_W(10)) u_big (
    .clk(clk), .reset(reset), .start(stL), .in_a(aL), .in_b(bL), .in_m(mL),
    .result(resL), .done(doneL), .busy(busyL));

  typedef struct {
    string      name;
    logic [7:0] a, b, m;
    int         exp;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         dcyc[4];
  int         ndone[4];
  logic [7:0] rcap[4];
  logic [31:0] btr;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Without final subtraction the result may carry one extra multiple of m.
  function automatic bit res_ok(input logic [7:0] r, input int e, input int m);
`ifdef MONT_FINAL_SUB_EN
    return int'(r) == e;
`else
    return (int'(r) == e) || (int'(r) == e + m);
`endif
  endfunction

  task automatic run8(input logic [3:0] mask, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] m, input int ncyc);
    for (int k = 0; k < 4; k++) begin
      dcyc[k] = -1; ndone[k] = 0; rcap[k] = '0;
    end
    btr = '0;
    @(posedge clk); #1;
    a8 = a; b8 = b; m8 = m; st = mask;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      st = '0;
      if (c == 1) begin a8 = 8'hA5; b8 = 8'h5A; m8 = 8'h3F; end
      btr[c] = busy8[1];
      for (int k = 0; k < 4; k++) begin
        if (done8[k]) begin
          ndone[k]++;
          if (dcyc[k] < 0) begin dcyc[k] = c; rcap[k] = res8[k]; end
        end
      end
    end
  endtask

  vec_t       vecs[$];
  int         dq[$];
  logic [7:0] rq[$];
  logic [7:0] held;
  int         cnt;
  logic [WL-1:0]   sa, sb, sm, r;
  logic [2*WL-1:0] lhs, rhs;
  bit              got, rng;
  int              cyc;

  initial begin
    reset = 1'b1; st = '0; stL = 1'b0;
    a8 = '0; b8 = '0; m8 = '0; aL = '0; bL = '0; mL = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_result_k%0d", 1 << k), res8[k] == 0, res8[k], 0);
      check($sformatf("rst_done_k%0d", 1 << k), done8[k] == 0, done8[k], 0);
      check($sformatf("rst_busy_k%0d", 1 << k), busy8[k] == 0, busy8[k], 0);
    end
    check("rst_big_done_busy", {doneL, busyL} == 2'b00, {doneL, busyL}, 0);
    reset = 1'b0;

    vecs.push_back('{"basic",   8'd5,   8'd7,   8'd13,  1});
    vecs.push_back('{"zero",    8'd0,   8'd12,  8'd13,  0});
    vecs.push_back('{"one",     8'd1,   8'd1,   8'd13,  3});
    vecs.push_back('{"m11",     8'd3,   8'd4,   8'd11,  4});
    vecs.push_back('{"m127",    8'd126, 8'd126, 8'd127, 64});
`ifdef MONT_FINAL_SUB_EN
    vecs.push_back('{"m251",    8'd250, 8'd250, 8'd251, 201});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run8(4'hF, vecs[i].a, vecs[i].b, vecs[i].m, 14);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("%s_k%0d_done_cyc", vecs[i].name, 1 << k),
              dcyc[k] == (W >> k) + XTRA, dcyc[k], (W >> k) + XTRA);
        check($sformatf("%s_k%0d_done_cnt", vecs[i].name, 1 << k), ndone[k] == 1, ndone[k], 1);
        check($sformatf("%s_k%0d_result", vecs[i].name, 1 << k),
              res_ok(rcap[k], vecs[i].exp, int'(vecs[i].m)), rcap[k], vecs[i].exp);
      end
      if (i == 0) check("basic_busy_trace", btr == 32'((1 << LAT) - 2), btr, (1 << LAT) - 2);
    end

    // Second start pulse in cycle 3 of a running operation must be ignored.
    dq.delete(); rq.delete();
    @(posedge clk); #1;
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; st = 4'b0010;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      st = (c == 3) ? 4'b0010 : 4'b0000;
      if (c == 3) begin a8 = 8'd1; b8 = 8'd1; end
      if (done8[1]) begin dq.push_back(c); rq.push_back(res8[1]); end
    end
    check("hs1_done_cnt", dq.size() == 1, dq.size(), 1);
    if (dq.size() >= 1) begin
      check("hs1_done_cyc", dq[0] == LAT, dq[0], LAT);
      check("hs1_result", res_ok(rq[0], 1, 13), rq[0], 1);
    end
    check("hs1_result_after", res_ok(res8[1], 1, 13), res8[1], 1);

    // Start held through done: back-to-back operation accepted in the done cycle.
    dq.delete(); rq.delete(); held = '0;
    @(posedge clk); #1;
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; st = 4'b0010;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin a8 = 8'd1; b8 = 8'd1; end
      if (c == LAT + 1) st = 4'b0000;
      if (done8[1]) begin dq.push_back(c); rq.push_back(res8[1]); end
      if (c == LAT + 2) held = res8[1];
    end
    check("hs2_done_cnt", dq.size() == 2, dq.size(), 2);
    if (dq.size() >= 2) begin
      check("hs2_done1_cyc", dq[0] == LAT, dq[0], LAT);
      check("hs2_done2_cyc", dq[1] == 2 * LAT, dq[1], 2 * LAT);
      check("hs2_result1", res_ok(rq[0], 1, 13), rq[0], 1);
      check("hs2_result2", res_ok(rq[1], 3, 13), rq[1], 3);
    end
    check("hs2_result_held", res_ok(held, 1, 13), held, 1);

    // Reset in cycle 3 aborts the operation.
    @(posedge clk); #1;
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; st = 4'b0010;
    @(posedge clk); #1; st = '0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("rstmid_done", done8[1] == 1'b0, done8[1], 0);
    check("rstmid_busy", busy8[1] == 1'b0, busy8[1], 0);
    check("rstmid_result", res8[1] == 8'd0, res8[1], 0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done8[1]) cnt++;
    end
    check("rstmid_no_done", cnt == 0, cnt, 0);
    run8(4'b0010, 8'd5, 8'd7, 8'd13, 14);
    check("rstmid_fresh_done_cyc", dcyc[1] == LAT, dcyc[1], LAT);
    check("rstmid_fresh_result", res_ok(rcap[1], 1, 13), rcap[1], 1);

    // 1024-bit vectors checked by congruence: r*2^WL == a*b (mod m).
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < WL / 32; i++) begin
        sm[i*32 +: 32] = $urandom;
        sa[i*32 +: 32] = $urandom;
        sb[i*32 +: 32] = $urandom;
      end
      sm[WL-1] = 1'b0; sm[WL-2] = 1'b1; sm[0] = 1'b1;
      sa = sa % sm; sb = sb % sm;
      if (n == 0) begin sa = sm - 1'b1; sb = sm - 1'b1; end
      @(posedge clk); #1;
      aL = sa; bL = sb; mL = sm; stL = 1'b1;
      got = 1'b0; cyc = 0; r = '0;
      for (int c = 1; c <= WL / 2 + 8 && !got; c++) begin
        @(posedge clk); #1;
        stL = 1'b0;
        aL = '0; bL = '0; mL = '0;
        if (doneL) begin got = 1'b1; cyc = c; r = resL; end
      end
      check($sformatf("big%0d_done_cyc", n), cyc == WL / 2 + XTRA, cyc, WL / 2 + XTRA);
      lhs = ({{WL{1'b0}}, r} << WL) % {{WL{1'b0}}, sm};
      rhs = ({{WL{1'b0}}, sa} * {{WL{1'b0}}, sb}) % {{WL{1'b0}}, sm};
      check($sformatf("big%0d_congruent", n), lhs == rhs, lhs[63:0], rhs[63:0]);
`ifdef MONT_FINAL_SUB_EN
      rng = (r < sm);
`else
      rng = ({1'b0, r} < {sm, 1'b0});
`endif
      check($sformatf("big%0d_range", n), rng, r[63:0], sm[63:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
